// File: rtl/sprite_line_fetcher.sv
// Scanline sprite fetcher: scans every slot against a target line, reads one shape
// row per hit from sprite RAM into a shadow buffer, then publishes it in one swap.
module sprite_line_fetcher #(
  parameter int unsigned NUM_SPRITES = 64,
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [Y_W-1:0]                  line_v,
  input  logic [NUM_SPRITES*ID_W-1:0]     sprite_id,
  input  logic [NUM_SPRITES*Y_W-1:0]      sprite_y,
  input  logic [NUM_SPRITES-1:0]          sprite_flip,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic                            mem_rd,
  input  logic [SPRITE_W-1:0]             mem_data,
  output logic [NUM_SPRITES*SPRITE_W-1:0] shape_out,
  output logic [NUM_SPRITES-1:0]          hit_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  localparam int unsigned IdxW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StRead, StWait, StSwap} state_e;

  state_e                          state_q, state_d;
  logic [Y_W-1:0]                  cur_v_q, cur_v_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [2:0]                      lat_q, lat_d;
  logic [NUM_SPRITES*SPRITE_W-1:0] shadow_q, shadow_d;
  logic [NUM_SPRITES-1:0]          smask_q, smask_d;
  logic [NUM_SPRITES*SPRITE_W-1:0] shape_q, shape_d;
  logic [NUM_SPRITES-1:0]          hmask_q, hmask_d;
  logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
  logic                            mem_rd_q, mem_rd_d;
  logic                            overrun_q, overrun_d;

  logic [ID_W-1:0]   slot_id;
  logic [Y_W-1:0]    slot_y;
  logic              slot_flip;
  logic [Y_W:0]      diff;
  int unsigned       diff_u, row_u, addr_u;
  logic              hit;
  logic [ADDR_W-1:0] addr_calc;
  logic              last;

  // Decode the current slot: vertical hit test and shape-row address.
  always_comb begin
    slot_id   = sprite_id[idx_q*ID_W +: ID_W];
    slot_y    = sprite_y[idx_q*Y_W +: Y_W];
    slot_flip = sprite_flip[idx_q];
    // Extra top bit flags a sprite starting below the line; no wraparound.
    diff      = {1'b0, cur_v_q} - {1'b0, slot_y};
    diff_u    = 32'(diff);
    hit       = (slot_id != '0) && !diff[Y_W] && (diff_u < SPRITE_H);
    row_u     = slot_flip ? (SPRITE_H - 1 - diff_u) : diff_u;
    addr_u    = 32'(slot_id) * SPRITE_H + row_u;
    addr_calc = ADDR_W'(addr_u);
    last      = (idx_q == LastIdx);
  end

  // Fetch sequencer: next state and register updates.
  always_comb begin
    state_d    = state_q;
    cur_v_d    = cur_v_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    shadow_d   = shadow_q;
    smask_d    = smask_q;
    shape_d    = shape_q;
    hmask_d    = hmask_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    overrun_d  = start && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_v_d  = line_v;
          shadow_d = '0;
          smask_d  = '0;
          idx_d    = '0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (hit) begin
          mem_addr_d = addr_calc;
          mem_rd_d   = 1'b1;
          state_d    = StRead;
        end else if (last) begin
          state_d = StSwap;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StRead: begin
        lat_d   = 3'(RD_LAT);
        state_d = StWait;
      end
      StWait: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          shadow_d[idx_q*SPRITE_W +: SPRITE_W] = mem_data;
          smask_d[idx_q]                       = 1'b1;
          if (last) begin
            state_d = StSwap;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StCheck;
          end
        end
      end
      StSwap: begin
        shape_d = shadow_q;
        hmask_d = smask_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_v_q    <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      shadow_q   <= '0;
      smask_q    <= '0;
      shape_q    <= '0;
      hmask_q    <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_v_q    <= cur_v_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      shadow_q   <= shadow_d;
      smask_q    <= smask_d;
      shape_q    <= shape_d;
      hmask_q    <= hmask_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      overrun_q  <= overrun_d;
    end
  end

  // Output drive.
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_rd    = mem_rd_q;
    shape_out = shape_q;
    hit_mask  = hmask_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StSwap);
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: one DUT at RD_LAT=1, one at RD_LAT=3.
module tb_sprite_line_fetcher;

  logic clk = 1'b0;
  logic rst, start;
  logic [9:0]   line_v;
  logic [383:0] sprite_id;
  logic [639:0] sprite_y;
  logic [63:0]  sprite_flip;

  logic [15:0]   mem_addr1, mem_data1, mem_addr3, mem_data3;
  logic          mem_rd1, mem_rd3;
  logic [1023:0] shape1, shape3;
  logic [63:0]   hit1, hit3;
  logic          busy1, done1, ovr1, busy3, done3, ovr3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_line_fetcher #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .line_v(line_v), .sprite_id(sprite_id),
    .sprite_y(sprite_y), .sprite_flip(sprite_flip), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_data(mem_data1), .shape_out(shape1), .hit_mask(hit1), .busy(busy1), .done(done1),
    .overrun(ovr1)
  );

  sprite_line_fetcher #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .line_v(line_v), .sprite_id(sprite_id),
    .sprite_y(sprite_y), .sprite_flip(sprite_flip), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .mem_data(mem_data3), .shape_out(shape3), .hit_mask(hit3), .busy(busy3), .done(done3),
    .overrun(ovr3)
  );

  // RAM models returning data = address, valid only in the exact latency cycle.
  logic        v1;
  logic [15:0] d1;
  logic [2:0]  v3;
  logic [15:0] d3 [3];
  always @(posedge clk) begin
    v1    <= mem_rd1;
    d1    <= mem_addr1;
    v3    <= {v3[1:0], mem_rd3};
    d3[0] <= mem_addr3;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign mem_data1 = v1 ? d1 : 16'hdead;
  assign mem_data3 = v3[2] ? d3[2] : 16'hdead;

  task automatic clear_slots();
    sprite_id = '0;
    sprite_y = '0;
    sprite_flip = '0;
  endtask

  task automatic set_slot(input int s, input int id, input int y, input bit f);
    sprite_id[s*6 +: 6] = 6'(id);
    sprite_y[s*10 +: 10] = 10'(y);
    sprite_flip[s] = f;
  endtask

  // Runs one fetch on the selected DUT; lat = cycles from start to done (-1 on timeout).
  task automatic run_fetch(input bit sel, input int line, output int lat, output int nrd,
                           output int addr);
    repeat (4) @(negedge clk);
    line_v = 10'(line);
    start = 1'b1;
    lat = -1;
    nrd = 0;
    addr = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sel ? mem_rd3 : mem_rd1) begin
        nrd++;
        addr = int'(sel ? mem_addr3 : mem_addr1);
      end
      if (sel ? done3 : done1) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    line_v = '0;
    clear_slots();
    repeat (2) @(negedge clk);
    checks++; if ({mem_addr1, mem_rd1, busy1, done1, ovr1} !== '0)
      begin errors++; $display("FAIL reset_ctrl: got %h want 0", {mem_addr1, mem_rd1, busy1, done1, ovr1}); end
    checks++; if (shape1 !== '0 || hit1 !== '0)
      begin errors++; $display("FAIL reset_bufs: got mask %h want 0", hit1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    int lat, nrd, addr;
    clear_slots();
    set_slot(63, 1, 33, 1'b0);
    run_fetch(1'b0, 40, lat, nrd, addr);
    checks++; if (lat !== 67) begin errors++; $display("FAIL single_lat: got %0d want 67", lat); end
    checks++; if (nrd !== 1) begin errors++; $display("FAIL single_nrd: got %0d want 1", nrd); end
    checks++; if (addr !== 23) begin errors++; $display("FAIL single_addr: got %0d want 23", addr); end
    checks++; if (shape1[63*16 +: 16] !== 16'd23)
      begin errors++; $display("FAIL single_data: got %0d want 23", shape1[63*16 +: 16]); end
    checks++; if (hit1 !== 64'h8000_0000_0000_0000)
      begin errors++; $display("FAIL single_mask: got %h want 8000000000000000", hit1); end
  endtask

  task automatic test_flip();
    int lat, nrd, addr;
    clear_slots();
    set_slot(63, 1, 33, 1'b1);
    run_fetch(1'b0, 40, lat, nrd, addr);
    checks++; if (addr !== 24) begin errors++; $display("FAIL flip_addr: got %0d want 24", addr); end
    checks++; if (shape1[63*16 +: 16] !== 16'd24)
      begin errors++; $display("FAIL flip_data: got %0d want 24", shape1[63*16 +: 16]); end
  endtask

  task automatic test_boundaries();
    int lat, nrd, addr;
    int lines [4] = '{32, 33, 48, 49};
    int want [4] = '{-1, 16, 31, -1};
    clear_slots();
    set_slot(63, 1, 33, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_fetch(1'b0, lines[i], lat, nrd, addr);
      checks++; if (addr !== want[i])
        begin errors++; $display("FAIL bound_%0d: got addr %0d want %0d", lines[i], addr, want[i]); end
      checks++; if (hit1[63] !== (want[i] >= 0))
        begin errors++; $display("FAIL bound_mask_%0d: got %b want %b", lines[i], hit1[63], want[i] >= 0); end
      checks++; if (lat !== ((want[i] >= 0) ? 67 : 65))
        begin errors++; $display("FAIL bound_lat_%0d: got %0d", lines[i], lat); end
    end
  endtask

  task automatic test_no_wrap();
    int lat, nrd, addr;
    clear_slots();
    set_slot(63, 1, 1020, 1'b0);
    run_fetch(1'b0, 1023, lat, nrd, addr);
    checks++; if (addr !== 19) begin errors++; $display("FAIL wrap_bottom: got %0d want 19", addr); end
    run_fetch(1'b0, 2, lat, nrd, addr);
    checks++; if (nrd !== 0 || hit1 !== '0)
      begin errors++; $display("FAIL wrap_low: got nrd %0d mask %h want 0", nrd, hit1); end
  endtask

  task automatic test_empty_slot();
    int lat, nrd, addr;
    clear_slots();
    set_slot(5, 0, 33, 1'b0);
    run_fetch(1'b0, 40, lat, nrd, addr);
    checks++; if (nrd !== 0) begin errors++; $display("FAIL empty_nrd: got %0d want 0", nrd); end
    checks++; if (shape1 !== '0 || hit1 !== '0)
      begin errors++; $display("FAIL empty_bufs: got mask %h want 0", hit1); end
  endtask

  task automatic test_overrun();
    int lat, nrd, addr, novr;
    clear_slots();
    set_slot(63, 1, 33, 1'b0);
    run_fetch(1'b0, 40, lat, nrd, addr);
    repeat (4) @(negedge clk);
    line_v = 10'd41;
    start = 1'b1;
    lat = -1;
    novr = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (ovr1) novr++;
      if (done1) begin
        lat = c;
        checks++; if (shape1[63*16 +: 16] !== 16'd23)
          begin errors++; $display("FAIL dbuf_hold: got %0d want 23", shape1[63*16 +: 16]); end
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (novr !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", novr); end
    checks++; if (lat !== 67) begin errors++; $display("FAIL ovr_lat: got %0d want 67", lat); end
    checks++; if (shape1[63*16 +: 16] !== 16'd24)
      begin errors++; $display("FAIL dbuf_new: got %0d want 24", shape1[63*16 +: 16]); end
  endtask

  task automatic test_latency();
    int lat, nrd, addr;
    clear_slots();
    set_slot(10, 2, 100, 1'b1);
    set_slot(63, 1, 90, 1'b0);
    run_fetch(1'b1, 103, lat, nrd, addr);
    checks++; if (lat !== 73) begin errors++; $display("FAIL lat3_cycles: got %0d want 73", lat); end
    checks++; if (nrd !== 2) begin errors++; $display("FAIL lat3_nrd: got %0d want 2", nrd); end
    checks++; if (shape3[10*16 +: 16] !== 16'd44)
      begin errors++; $display("FAIL lat3_s10: got %0d want 44", shape3[10*16 +: 16]); end
    checks++; if (shape3[63*16 +: 16] !== 16'd29)
      begin errors++; $display("FAIL lat3_s63: got %0d want 29", shape3[63*16 +: 16]); end
    checks++; if (hit3 !== 64'h8000_0000_0000_0400)
      begin errors++; $display("FAIL lat3_mask: got %h want 8000000000000400", hit3); end
  endtask

  task automatic test_reset_mid_fetch();
    int ndone;
    clear_slots();
    set_slot(63, 1, 33, 1'b0);
    repeat (4) @(negedge clk);
    line_v = 10'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++; if ({mem_addr1, mem_rd1, busy1, done1, ovr1} !== '0)
      begin errors++; $display("FAIL midrst_ctrl: got %h want 0", {mem_addr1, mem_rd1, busy1, done1, ovr1}); end
    checks++; if (shape1 !== '0 || hit1 !== '0)
      begin errors++; $display("FAIL midrst_bufs: got mask %h want 0", hit1); end
    ndone = 0;
    repeat (100) begin
      @(negedge clk);
      if (done1 || busy1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_done: got %0d want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_flip();
    test_boundaries();
    test_no_wrap();
    test_empty_slot();
    test_overrun();
    test_latency();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Parametrised scanline sprite fetcher, next generation of the sprite shape reader. On each `start` it scans every sprite slot against a target scanline and fetches one shape row per hit from sprite RAM. Fetches honour an optional per-slot vertical flip and a configurable RAM read latency. Results go to a double-buffered line register that the pixel mixer reads while the next line is being fetched.

## Interface
- `NUM_SPRITES`, 64: sprite slots (levels). Slot i uses bits [i*W +: W] of each packed bus.
- `SPRITE_W`, 16: pixels per shape row. Also the RAM data width.
- `SPRITE_H`, 16: rows per sprite shape.
- `ID_W`, 6: sprite id width.
- `Y_W`, 10: coordinate width.
- `ADDR_W`, 16: RAM address width.
- `RD_LAT`, 1: RAM read latency in cycles, range 1..4.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse requesting a fetch for `line_v`.
- `line_v` in Y_W: target scanline, sampled on `start`.
- `sprite_id` in NUM_SPRITES*ID_W: shape id per slot. Id 0 means empty slot.
- `sprite_y` in NUM_SPRITES*Y_W: top row per slot.
- `sprite_flip` in NUM_SPRITES: per-slot vertical flip.
- `mem_addr` out ADDR_W: registered RAM address.
- `mem_rd` out 1: registered one-cycle read strobe.
- `mem_data` in SPRITE_W: RAM read data.
- `shape_out` out NUM_SPRITES*SPRITE_W: published shape rows for the current line.
- `hit_mask` out NUM_SPRITES: published per-slot hit flags.
- `busy` out 1: fetch in progress.
- `done` out 1: one-cycle pulse when the new line is published.
- `overrun` out 1: one-cycle pulse when `start` arrives while `busy`.

## Operation
- States are IDLE, CHECK, READ, WAIT, SWAP.
- **IDLE**
  - On `start`: latch `line_v` into `cur_v`, clear the shadow buffer and shadow mask, set slot index to 0, go to CHECK.
- **CHECK** (slot i)
  - Compute `diff = {1'b0,cur_v} - {1'b0,y_i}` in Y_W+1 bits.
  - Hit iff `id_i != 0`, `diff[Y_W] == 0` and `diff < SPRITE_H`.
  - No vertical wrap: a sprite near the bottom never hits low scanlines.
  - Miss: the shadow slot stays 0. If i is the last slot go to SWAP, else i+1 and stay in CHECK.
  - Hit: `row = flip_i ? SPRITE_H-1-diff : diff`. Register `mem_addr = id_i*SPRITE_H + row`, truncated mod 2^ADDR_W. Register `mem_rd = 1`. Go to READ.
- **READ**
  - `mem_rd` is high for exactly this cycle.
  - Load the latency counter with RD_LAT, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the cycle the counter expires, capture `mem_data` into shadow slot i and set shadow mask bit i.
  - Then go to SWAP if i is last, else CHECK slot i+1.
- **SWAP**
  - Copy shadow buffer to `shape_out` and shadow mask to `hit_mask`.
  - Pulse `done`, go to IDLE.
- Published outputs change only in SWAP. They stay stable for the whole of the next fetch.
- `sprite_id`, `sprite_y` and `sprite_flip` are read live in CHECK. The producer holds them stable while `busy`.

## Timing
- Reset (`rst` low at a rising edge): all outputs 0, state IDLE, shadow and published buffers cleared.
- Reset mid-fetch aborts the fetch. No `done` is issued.
- `busy` is high from the cycle after `start` is sampled through the SWAP cycle inclusive.
- Per-slot cost: a miss is 1 cycle. A hit is 2+RD_LAT cycles (CHECK, READ, RD_LAT WAIT cycles).
- Total latency from `start` to `done`: (misses) + (hits × (2+RD_LAT)) + 1 cycles.
- Worst case for the default parameters is 64×3+1 = 193 cycles. This fits in one 50 MHz line period of 1600 cycles.
- `mem_data` must be valid RD_LAT cycles after the READ cycle. It is captured at the end of the last WAIT cycle.
- `start` while `busy`, including in the SWAP cycle: ignored, `overrun` pulses the next cycle, and the current fetch is unaffected.
- `start` in IDLE in the cycle right after `done` is accepted normally.

## Test plan
- **Reset:** hold `rst` low 2 cycles during a fetch -> next cycle all outputs 0, `busy` 0, no `done`.
- **Single hit:** slot 63 id=1 y=33 no flip, other slots id 0, `line_v`=40, RAM returns data=addr -> one `mem_rd` with `mem_addr`=23. `done` is high 67 cycles after `start` (63 misses at 1 cycle, hit at 3, swap at 1). `shape_out[63]`=23, `hit_mask`=bit 63 only.
- **Flip:** same setup with `sprite_flip[63]`=1 -> `mem_addr`=24, `shape_out[63]`=24.
- **Vertical boundaries** (y=33):
  - `line_v`=32 -> miss.
  - `line_v`=33 -> addr 16.
  - `line_v`=48 -> addr 31.
  - `line_v`=49 -> miss.
- **No wrap** (y=1020):
  - `line_v`=1023 -> row 3.
  - `line_v`=2 -> miss.
- **Empty slot:** id 0 with matching y -> no `mem_rd`, slot data 0, mask bit 0.
- **Overrun and double buffer:** `start` mid-fetch -> `overrun` pulses once and the first fetch completes normally. `shape_out` keeps its previous line values until SWAP.
- **Latency:** RD_LAT=3 with a 3-cycle RAM model -> each hit costs 5 cycles and data is captured correctly.
